// File: rtl/posit_operand_sequencer_if.sv
// Operand-pair request and decoded-result handshake between a client and the posit operand sequencer.
interface posit_operand_sequencer_if;
    logic               in_valid;
    logic               in_ready;
    logic [31:0]        posit_a;
    logic [31:0]        posit_b;

    logic               out_valid;
    logic               out_ready;
    logic               out_err;

    logic               a_sign;
    logic               a_zero;
    logic               a_nar;
    logic signed [5:0]  a_k;
    logic [2:0]         a_exp;
    logic [31:0]        a_mant;

    logic               b_sign;
    logic               b_zero;
    logic               b_nar;
    logic signed [5:0]  b_k;
    logic [2:0]         b_exp;
    logic [31:0]        b_mant;

    modport master (
        output in_valid, posit_a, posit_b, out_ready,
        input  in_ready, out_valid, out_err,
        input  a_sign, a_zero, a_nar, a_k, a_exp, a_mant,
        input  b_sign, b_zero, b_nar, b_k, b_exp, b_mant
    );

    modport slave (
        input  in_valid, posit_a, posit_b, out_ready,
        output in_ready, out_valid, out_err,
        output a_sign, a_zero, a_nar, a_k, a_exp, a_mant,
        output b_sign, b_zero, b_nar, b_k, b_exp, b_mant
    );
endinterface

// File: rtl/posit_operand_sequencer.sv
// Feeds posit_a then posit_b through a shared posit decoder, captures both decodes
// and presents them on a valid/ready result port, aborting with out_err on a stalled decoder.
module posit_operand_sequencer #(
    parameter int TIMEOUT = 63
) (
    input  logic                     clk,
    input  logic                     rst,
    posit_operand_sequencer_if.slave bus,
    output logic [31:0]              dec_posit_num,
    output logic                     dec_start,
    output logic                     dec_received,
    input  logic                     dec_done,
    input  logic                     dec_sign,
    input  logic                     dec_zero,
    input  logic                     dec_nar,
    input  logic signed [5:0]        dec_k,
    input  logic [2:0]               dec_exp,
    input  logic [31:0]              dec_mant
);
    typedef enum logic [2:0] {
        IDLE, START_A, WAIT_A, REL_A, START_B, WAIT_B, REL_B, OUT
    } state_t;

    localparam logic [6:0] TIMEOUT_CNT = 7'(TIMEOUT);

    state_t      state;
    logic [31:0] hold_b;
    logic [6:0]  wd_cnt;

    // dec_posit_num doubles as the hold register for operand A, so only B needs its own copy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            hold_b        <= '0;
            wd_cnt        <= '0;
            dec_posit_num <= '0;
            dec_start     <= 1'b0;
            dec_received  <= 1'b0;
            bus.in_ready  <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_err   <= 1'b0;
            bus.a_sign    <= 1'b0;
            bus.a_zero    <= 1'b0;
            bus.a_nar     <= 1'b0;
            bus.a_k       <= '0;
            bus.a_exp     <= '0;
            bus.a_mant    <= '0;
            bus.b_sign    <= 1'b0;
            bus.b_zero    <= 1'b0;
            bus.b_nar     <= 1'b0;
            bus.b_k       <= '0;
            bus.b_exp     <= '0;
            bus.b_mant    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_ready && bus.in_valid) begin
                        dec_posit_num <= bus.posit_a;
                        hold_b        <= bus.posit_b;
                        dec_start     <= 1'b1;
                        bus.in_ready  <= 1'b0;
                        state         <= START_A;
                    end else begin
                        bus.in_ready  <= 1'b1;
                    end
                end

                START_A, START_B: begin
                    dec_start <= 1'b0;
                    wd_cnt    <= '0;
                    state     <= (state == START_A) ? WAIT_A : WAIT_B;
                end

                // A stalled A operand leaves B undecoded too, so both sides are cleared.
                WAIT_A: begin
                    if (dec_done) begin
                        bus.a_sign   <= dec_sign;
                        bus.a_zero   <= dec_zero;
                        bus.a_nar    <= dec_nar;
                        bus.a_k      <= dec_k;
                        bus.a_exp    <= dec_exp;
                        bus.a_mant   <= dec_mant;
                        dec_received <= 1'b1;
                        state        <= REL_A;
                    end else if (wd_cnt == TIMEOUT_CNT) begin
                        bus.a_sign    <= 1'b0;
                        bus.a_zero    <= 1'b0;
                        bus.a_nar     <= 1'b0;
                        bus.a_k       <= '0;
                        bus.a_exp     <= '0;
                        bus.a_mant    <= '0;
                        bus.b_sign    <= 1'b0;
                        bus.b_zero    <= 1'b0;
                        bus.b_nar     <= 1'b0;
                        bus.b_k       <= '0;
                        bus.b_exp     <= '0;
                        bus.b_mant    <= '0;
                        bus.out_err   <= 1'b1;
                        bus.out_valid <= 1'b1;
                        state         <= OUT;
                    end else begin
                        wd_cnt <= wd_cnt + 7'd1;
                    end
                end

                WAIT_B: begin
                    if (dec_done) begin
                        bus.b_sign   <= dec_sign;
                        bus.b_zero   <= dec_zero;
                        bus.b_nar    <= dec_nar;
                        bus.b_k      <= dec_k;
                        bus.b_exp    <= dec_exp;
                        bus.b_mant   <= dec_mant;
                        dec_received <= 1'b1;
                        state        <= REL_B;
                    end else if (wd_cnt == TIMEOUT_CNT) begin
                        bus.b_sign    <= 1'b0;
                        bus.b_zero    <= 1'b0;
                        bus.b_nar     <= 1'b0;
                        bus.b_k       <= '0;
                        bus.b_exp     <= '0;
                        bus.b_mant    <= '0;
                        bus.out_err   <= 1'b1;
                        bus.out_valid <= 1'b1;
                        state         <= OUT;
                    end else begin
                        wd_cnt <= wd_cnt + 7'd1;
                    end
                end

                // The decoder holds done one cycle past the acknowledge; the next start waits for it to drop.
                REL_A: begin
                    if (!dec_done) begin
                        dec_received  <= 1'b0;
                        dec_posit_num <= hold_b;
                        dec_start     <= 1'b1;
                        state         <= START_B;
                    end
                end

                REL_B: begin
                    if (!dec_done) begin
                        dec_received  <= 1'b0;
                        bus.out_valid <= 1'b1;
                        state         <= OUT;
                    end
                end

                OUT: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.out_err   <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        state         <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_posit_operand_sequencer.sv
// Directed bench for posit_operand_sequencer with a behavioural es=3 posit decoder model.
module tb_posit_operand_sequencer;
    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic [31:0]        dec_posit_num;
    logic               dec_start;
    logic               dec_received;
    logic               dec_done;
    logic               dec_sign;
    logic               dec_zero;
    logic               dec_nar;
    logic signed [5:0]  dec_k;
    logic [2:0]         dec_exp;
    logic [31:0]        dec_mant;

    int  dec_lat  = 1;
    bit  dec_dead = 1'b0;
    int  n_checks = 0;
    int  n_fail   = 0;
    int  start_cnt = 0;
    int  conflict_cnt = 0;
    int  long_start_cnt = 0;

    posit_operand_sequencer_if bus();

    posit_operand_sequencer #(.TIMEOUT(63)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .dec_posit_num (dec_posit_num),
        .dec_start     (dec_start),
        .dec_received  (dec_received),
        .dec_done      (dec_done),
        .dec_sign      (dec_sign),
        .dec_zero      (dec_zero),
        .dec_nar       (dec_nar),
        .dec_k         (dec_k),
        .dec_exp       (dec_exp),
        .dec_mant      (dec_mant)
    );

    logic [43:0] a_fields;
    logic [43:0] b_fields;
    assign a_fields = {bus.a_sign, bus.a_zero, bus.a_nar, bus.a_k, bus.a_exp, bus.a_mant};
    assign b_fields = {bus.b_sign, bus.b_zero, bus.b_nar, bus.b_k, bus.b_exp, bus.b_mant};

    initial forever #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation exceeded its time limit");
        $fatal(1, "[TB] global timeout");
    end

    task automatic decode_posit(input logic [31:0] p);
        logic [31:0] v;
        int run;
        dec_sign = p[31];
        dec_zero = (p == 32'h0000_0000);
        dec_nar  = (p == 32'h8000_0000);
        dec_k    = '0;
        dec_exp  = '0;
        dec_mant = '0;
        if (!dec_zero && !dec_nar) begin
            v = (p[31] ? -p : p) << 1;
            run = 0;
            while (run < 31 && v[31-run] == v[31]) run++;
            dec_k = v[31] ? 6'(run - 1) : 6'(-run);
            v = v << (run + 1);
            dec_exp = v[31:29];
            v = v << 3;
            dec_mant = {1'b1, v[31:1]};
        end
    endtask

    // Decoder model: done after dec_lat cycles, held one extra cycle after dec_received.
    initial begin
        logic [31:0] latched;
        bit busy, acked;
        int cnt;
        busy = 0; acked = 0; cnt = 0; latched = '0;
        dec_done = 0; dec_sign = 0; dec_zero = 0; dec_nar = 0;
        dec_k = '0; dec_exp = '0; dec_mant = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                busy = 0; acked = 0; cnt = 0; dec_done = 0;
                decode_posit(32'h0);
                dec_zero = 0;
            end else if (dec_done) begin
                if (acked) begin
                    dec_done = 0; acked = 0;
                end else if (dec_received) begin
                    acked = 1;
                end
            end else if (busy) begin
                cnt++;
                if (cnt >= dec_lat) begin
                    busy = 0;
                    dec_done = 1;
                    decode_posit(latched);
                end
            end else if (dec_start && !dec_dead) begin
                busy = 1; cnt = 0; latched = dec_posit_num;
            end
        end
    end

    initial begin
        bit start_prev;
        start_prev = 0;
        forever begin
            @(posedge clk);
            #2;
            if (dec_start && dec_done) conflict_cnt++;
            if (dec_start && start_prev) long_start_cnt++;
            if (dec_start && !start_prev) start_cnt++;
            start_prev = dec_start;
        end
    end

    task automatic send_pair(input logic [31:0] a, input logic [31:0] b, output bit ok);
        ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (bus.in_ready) ok = 1;
        end
        if (ok) begin
            bus.posit_a  = a;
            bus.posit_b  = b;
            bus.in_valid = 1'b1;
            @(negedge clk);
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic wait_out(input int budget, output int cycles);
        cycles = 0;
        while (!bus.out_valid && cycles < budget) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic release_out();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_in_ready: got %b expected 0", bus.in_ready); end
        n_checks++; if ({bus.out_valid, bus.out_err, dec_start, dec_received} !== 4'b0) begin n_fail++; $display("[TB] FAIL reset_ctrl: got %b expected 0000", {bus.out_valid, bus.out_err, dec_start, dec_received}); end
        n_checks++; if (dec_posit_num !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_posit_num: got %h expected 0", dec_posit_num); end
        n_checks++; if ({a_fields, b_fields} !== 88'h0) begin n_fail++; $display("[TB] FAIL reset_fields: got %h %h expected 0", a_fields, b_fields); end
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_release_in_ready: got %b expected 1", bus.in_ready); end
    endtask

    task automatic test_basic();
        int base, cycles;
        bit ok;
        dec_lat = 3;
        base = start_cnt;
        send_pair(32'h4000_0000, 32'h4000_0000, ok);
        n_checks++; if (!ok) begin n_fail++; $display("[TB] FAIL basic_accept: in_ready got 0 expected 1 within budget"); end
        wait_out(200, cycles);
        n_checks++; if (cycles + 1 != 13) begin n_fail++; $display("[TB] FAIL basic_latency: got %0d expected 13", cycles + 1); end
        n_checks++; if (a_fields !== {3'b000, 6'd0, 3'd0, 32'h8000_0000}) begin n_fail++; $display("[TB] FAIL basic_a: got %h expected %h", a_fields, {3'b000, 6'd0, 3'd0, 32'h8000_0000}); end
        n_checks++; if (b_fields !== {3'b000, 6'd0, 3'd0, 32'h8000_0000}) begin n_fail++; $display("[TB] FAIL basic_b: got %h expected %h", b_fields, {3'b000, 6'd0, 3'd0, 32'h8000_0000}); end
        n_checks++; if (bus.out_err !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_err: got %b expected 0", bus.out_err); end
        n_checks++; if (start_cnt - base != 2) begin n_fail++; $display("[TB] FAIL basic_starts: got %0d expected 2", start_cnt - base); end
        release_out();
        n_checks++; if ({bus.out_valid, bus.in_ready} !== 2'b01) begin n_fail++; $display("[TB] FAIL basic_release: got valid/ready %b expected 01", {bus.out_valid, bus.in_ready}); end
    endtask

    task automatic test_special();
        int cycles;
        bit ok;
        dec_lat = 1;
        send_pair(32'h0000_0000, 32'h8000_0000, ok);
        wait_out(200, cycles);
        n_checks++; if (cycles + 1 != 9) begin n_fail++; $display("[TB] FAIL special_latency: got %0d expected 9", cycles + 1); end
        n_checks++; if (a_fields !== {3'b010, 6'd0, 3'd0, 32'h0}) begin n_fail++; $display("[TB] FAIL special_a_zero: got %h expected %h", a_fields, {3'b010, 6'd0, 3'd0, 32'h0}); end
        n_checks++; if (b_fields !== {3'b101, 6'd0, 3'd0, 32'h0}) begin n_fail++; $display("[TB] FAIL special_b_nar: got %h expected %h", b_fields, {3'b101, 6'd0, 3'd0, 32'h0}); end
        n_checks++; if (bus.out_err !== 1'b0) begin n_fail++; $display("[TB] FAIL special_err: got %b expected 0", bus.out_err); end
        release_out();
    endtask

    task automatic test_fields();
        int cycles;
        bit ok;
        dec_lat = 2;
        send_pair(32'h5010_0000, 32'hE000_0000, ok);
        wait_out(200, cycles);
        n_checks++; if (a_fields !== {3'b000, 6'd0, 3'd4, 32'h8200_0000}) begin n_fail++; $display("[TB] FAIL fields_a: got %h expected %h", a_fields, {3'b000, 6'd0, 3'd4, 32'h8200_0000}); end
        n_checks++; if (b_fields !== {3'b100, 6'h3F, 3'd0, 32'h8000_0000}) begin n_fail++; $display("[TB] FAIL fields_b: got %h expected %h", b_fields, {3'b100, 6'h3F, 3'd0, 32'h8000_0000}); end
        release_out();
    endtask

    task automatic test_hold();
        int base, cycles;
        bit ok;
        dec_lat = 2;
        base = start_cnt;
        send_pair(32'h6000_0000, 32'h2000_0000, ok);
        wait_out(200, cycles);
        n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL hold_valid: got %b expected 1", bus.out_valid); end
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            bus.posit_a  = 32'h1234_5678;
            bus.posit_b  = 32'h9ABC_DEF0;
            @(negedge clk);
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || start_cnt - base != 2 ||
                a_fields !== {3'b000, 6'd1, 3'd0, 32'h8000_0000} ||
                b_fields !== {3'b000, 6'h3F, 3'd0, 32'h8000_0000}) begin
                n_fail++;
                $display("[TB] FAIL hold_cycle%0d: got valid=%b ready=%b starts=%0d a=%h b=%h expected valid=1 ready=0 starts=2 a=%h b=%h",
                         i, bus.out_valid, bus.in_ready, start_cnt - base, a_fields, b_fields,
                         {3'b000, 6'd1, 3'd0, 32'h8000_0000}, {3'b000, 6'h3F, 3'd0, 32'h8000_0000});
            end
        end
        bus.in_valid = 1'b0;
        release_out();
        n_checks++; if ({bus.out_valid, bus.in_ready} !== 2'b01) begin n_fail++; $display("[TB] FAIL hold_release: got valid/ready %b expected 01", {bus.out_valid, bus.in_ready}); end
    endtask

    task automatic test_timeout();
        int base, cycles;
        bit ok;
        dec_dead = 1'b1;
        base = start_cnt;
        send_pair(32'h4000_0000, 32'h6000_0000, ok);
        wait_out(200, cycles);
        n_checks++; if (cycles - 1 != 64) begin n_fail++; $display("[TB] FAIL timeout_cycles_from_wait: got %0d expected 64", cycles - 1); end
        n_checks++; if (bus.out_err !== 1'b1) begin n_fail++; $display("[TB] FAIL timeout_err: got %b expected 1", bus.out_err); end
        n_checks++; if (a_fields !== 44'h0) begin n_fail++; $display("[TB] FAIL timeout_a_zeroed: got %h expected 0", a_fields); end
        n_checks++; if (start_cnt - base != 1) begin n_fail++; $display("[TB] FAIL timeout_starts: got %0d expected 1", start_cnt - base); end
        release_out();
        n_checks++; if ({bus.out_valid, bus.out_err, bus.in_ready} !== 3'b001) begin n_fail++; $display("[TB] FAIL timeout_release: got valid/err/ready %b expected 001", {bus.out_valid, bus.out_err, bus.in_ready}); end
        dec_dead = 1'b0;
    endtask

    task automatic test_back_to_back();
        int base, cycles;
        bit ok;
        dec_lat = 1;
        base = start_cnt;
        send_pair(32'h4800_0000, 32'hC000_0000, ok);
        bus.in_valid = 1'b1;
        bus.posit_a  = 32'h7FFF_FFFF;
        bus.posit_b  = 32'h0000_0001;
        wait_out(200, cycles);
        bus.in_valid = 1'b0;
        n_checks++; if (a_fields !== {3'b000, 6'd0, 3'd2, 32'h8000_0000}) begin n_fail++; $display("[TB] FAIL b2b_first_a: got %h expected %h", a_fields, {3'b000, 6'd0, 3'd2, 32'h8000_0000}); end
        n_checks++; if (b_fields !== {3'b100, 6'd0, 3'd0, 32'h8000_0000}) begin n_fail++; $display("[TB] FAIL b2b_first_b: got %h expected %h", b_fields, {3'b100, 6'd0, 3'd0, 32'h8000_0000}); end
        n_checks++; if (start_cnt - base != 2) begin n_fail++; $display("[TB] FAIL b2b_first_starts: got %0d expected 2", start_cnt - base); end
        release_out();
        base = start_cnt;
        send_pair(32'h2000_0000, 32'h6000_0000, ok);
        wait_out(200, cycles);
        n_checks++; if (a_fields !== {3'b000, 6'h3F, 3'd0, 32'h8000_0000}) begin n_fail++; $display("[TB] FAIL b2b_second_a: got %h expected %h", a_fields, {3'b000, 6'h3F, 3'd0, 32'h8000_0000}); end
        n_checks++; if (b_fields !== {3'b000, 6'd1, 3'd0, 32'h8000_0000}) begin n_fail++; $display("[TB] FAIL b2b_second_b: got %h expected %h", b_fields, {3'b000, 6'd1, 3'd0, 32'h8000_0000}); end
        n_checks++; if (start_cnt - base != 2) begin n_fail++; $display("[TB] FAIL b2b_second_starts: got %0d expected 2", start_cnt - base); end
        release_out();
    endtask

    task automatic test_reset_mid();
        int base, cycles, seen;
        bit ok;
        dec_lat = 20;
        base = start_cnt;
        send_pair(32'h4000_0000, 32'hC000_0000, ok);
        seen = 0;
        while (start_cnt - base < 2 && seen < 200) begin
            @(negedge clk);
            seen++;
        end
        n_checks++; if (start_cnt - base != 2) begin n_fail++; $display("[TB] FAIL rmid_reach_b: got %0d starts expected 2", start_cnt - base); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++; if ({bus.in_ready, bus.out_valid, bus.out_err, dec_start, dec_received} !== 5'b0) begin n_fail++; $display("[TB] FAIL rmid_ctrl: got %b expected 00000", {bus.in_ready, bus.out_valid, bus.out_err, dec_start, dec_received}); end
        n_checks++; if ({a_fields, b_fields, dec_posit_num} !== 120'h0) begin n_fail++; $display("[TB] FAIL rmid_data: got %h %h %h expected 0", a_fields, b_fields, dec_posit_num); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL rmid_in_ready: got %b expected 1", bus.in_ready); end
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        n_checks++; if (seen != 0) begin n_fail++; $display("[TB] FAIL rmid_discard: got %0d out_valid cycles expected 0", seen); end
        dec_lat = 2;
        base = start_cnt;
        send_pair(32'h6000_0000, 32'h4010_0000, ok);
        wait_out(200, cycles);
        n_checks++; if (a_fields !== {3'b000, 6'd1, 3'd0, 32'h8000_0000}) begin n_fail++; $display("[TB] FAIL rmid_fresh_a: got %h expected %h", a_fields, {3'b000, 6'd1, 3'd0, 32'h8000_0000}); end
        n_checks++; if (b_fields !== {3'b000, 6'd0, 3'd0, 32'h8200_0000}) begin n_fail++; $display("[TB] FAIL rmid_fresh_b: got %h expected %h", b_fields, {3'b000, 6'd0, 3'd0, 32'h8200_0000}); end
        n_checks++; if (bus.out_err !== 1'b0) begin n_fail++; $display("[TB] FAIL rmid_fresh_err: got %b expected 0", bus.out_err); end
        release_out();
    endtask

    task automatic test_monitor();
        n_checks++; if (conflict_cnt != 0) begin n_fail++; $display("[TB] FAIL mon_start_while_done: got %0d cycles expected 0", conflict_cnt); end
        n_checks++; if (long_start_cnt != 0) begin n_fail++; $display("[TB] FAIL mon_start_width: got %0d extra cycles expected 0", long_start_cnt); end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.posit_a   = '0;
        bus.posit_b   = '0;
        test_reset();
        test_basic();
        test_special();
        test_fields();
        test_hold();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_monitor();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
